// File: rtl/morse_input_sequencer.sv
// Morse key front end: synchronises the key, times presses and gaps, and emits
// symbol, letter and word events. Define MORSE_DEBOUNCE_EN to build the debouncer.
module morse_input_sequencer #(
  parameter int CNT_W             = 28,
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int DOT_MAX_CYCLES    = 25000000,
  parameter int DASH_MAX_CYCLES   = 100000000,
  parameter int LETTER_GAP_CYCLES = 50000000,
  parameter int WORD_GAP_CYCLES   = 150000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       signal,
  output logic       pressed,
  output logic       symbol_valid,
  output logic       symbol_is_dash,
  output logic       letter_end,
  output logic [2:0] letter_len,
  output logic [4:0] letter_code,
  output logic       word_end,
  output logic       symbol_error
);

  typedef enum logic [1:0] {IDLE, PRESS, GAP, LONG} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] DOT_MAX_C    = CNT_W'(DOT_MAX_CYCLES);
  localparam logic [CNT_W-1:0] DASH_MAX_C   = CNT_W'(DASH_MAX_CYCLES);
  localparam logic [CNT_W-1:0] LETTER_GAP_C = CNT_W'(LETTER_GAP_CYCLES);
  localparam logic [CNT_W-1:0] WORD_GAP_C   = CNT_W'(WORD_GAP_CYCLES);

  logic sync1_reg, sync2_reg;
  logic sig_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= signal;
      sync2_reg <= sync1_reg;
    end
  end

`ifdef MORSE_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] db_cnt_reg;
  logic            sig_d_reg;

  // The level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt_reg <= '0;
      sig_d_reg  <= 1'b0;
    end else if (sync2_reg != sig_d_reg) begin
      if (db_cnt_reg == DB_LAST) begin
        sig_d_reg  <= sync2_reg;
        db_cnt_reg <= '0;
      end else begin
        db_cnt_reg <= db_cnt_reg + 1'b1;
      end
    end else begin
      db_cnt_reg <= '0;
    end
  end

  assign sig_d = sig_d_reg;
`else
  logic debounce_unused;
  assign debounce_unused = ^DEBOUNCE_CYCLES;
  assign sig_d = sync2_reg;
`endif

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [2:0]       len_reg, len_next;
  logic [4:0]       code_reg, code_next;
  logic             symbol_valid_reg, symbol_valid_next;
  logic             symbol_is_dash_reg, symbol_is_dash_next;
  logic             letter_end_reg, letter_end_next;
  logic [2:0]       letter_len_reg, letter_len_next;
  logic [4:0]       letter_code_reg, letter_code_next;
  logic             word_end_reg, word_end_next;
  logic             symbol_error_reg, symbol_error_next;
  logic             is_dash;

  assign cnt_inc = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;
  assign is_dash = (cnt_reg > DOT_MAX_C);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg          <= IDLE;
      cnt_reg            <= '0;
      len_reg            <= '0;
      code_reg           <= '0;
      symbol_valid_reg   <= 1'b0;
      symbol_is_dash_reg <= 1'b0;
      letter_end_reg     <= 1'b0;
      letter_len_reg     <= '0;
      letter_code_reg    <= '0;
      word_end_reg       <= 1'b0;
      symbol_error_reg   <= 1'b0;
    end else begin
      state_reg          <= state_next;
      cnt_reg            <= cnt_next;
      len_reg            <= len_next;
      code_reg           <= code_next;
      symbol_valid_reg   <= symbol_valid_next;
      symbol_is_dash_reg <= symbol_is_dash_next;
      letter_end_reg     <= letter_end_next;
      letter_len_reg     <= letter_len_next;
      letter_code_reg    <= letter_code_next;
      word_end_reg       <= word_end_next;
      symbol_error_reg   <= symbol_error_next;
    end
  end

  always_comb begin
    state_next          = state_reg;
    cnt_next            = cnt_inc;
    len_next            = len_reg;
    code_next           = code_reg;
    symbol_valid_next   = 1'b0;
    symbol_is_dash_next = 1'b0;
    letter_end_next     = 1'b0;
    letter_len_next     = letter_len_reg;
    letter_code_next    = letter_code_reg;
    word_end_next       = 1'b0;
    symbol_error_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (sig_d) begin
          state_next = PRESS;
          cnt_next   = CNT_ONE;
        end
      end

      PRESS: begin
        // cnt equals the press length on the first released cycle.
        if (cnt_reg == DASH_MAX_C) begin
          symbol_error_next = 1'b1;
          len_next          = '0;
          code_next         = '0;
          if (sig_d) begin
            state_next = LONG;
          end else begin
            state_next = GAP;
            cnt_next   = CNT_ONE;
          end
        end else if (!sig_d) begin
          state_next = GAP;
          cnt_next   = CNT_ONE;
          if (len_reg == 3'd5) begin
            symbol_error_next = 1'b1;
            len_next          = '0;
            code_next         = '0;
          end else begin
            symbol_valid_next   = 1'b1;
            symbol_is_dash_next = is_dash;
            code_next           = {code_reg[3:0], is_dash};
            len_next            = len_reg + 1'b1;
          end
        end
      end

      LONG: begin
        if (!sig_d) begin
          state_next = GAP;
          cnt_next   = CNT_ONE;
        end
      end

      GAP: begin
        if (cnt_reg == LETTER_GAP_C && len_reg != '0) begin
          letter_end_next  = 1'b1;
          letter_len_next  = len_reg;
          letter_code_next = code_reg;
          len_next         = '0;
          code_next        = '0;
        end
        if (cnt_reg == WORD_GAP_C) begin
          word_end_next = 1'b1;
        end
        if (sig_d) begin
          state_next = PRESS;
          cnt_next   = CNT_ONE;
        end else if (cnt_reg == WORD_GAP_C) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign pressed        = sig_d;
  assign symbol_valid   = symbol_valid_reg;
  assign symbol_is_dash = symbol_is_dash_reg;
  assign letter_end     = letter_end_reg;
  assign letter_len     = letter_len_reg;
  assign letter_code    = letter_code_reg;
  assign word_end       = word_end_reg;
  assign symbol_error   = symbol_error_reg;

endmodule
